sdram_line_fetch: RTL and testbench

Read-side requester for `sdram_ctrl`. It accepts line-aligned read requests on a valid/ready port and issues one burst read per request on the controller's internal `acc`/`ack` interface. The returned words are collected in an internal FIFO and presented downstream as a valid/ready word stream with a per-line `last` marker. It sits between a consumer (e.g. the video scan-out or blitter fetch path) and `sdram_ctrl`, taking the place of the ad-hoc drivers used during bring-up.

---
 rtl/sdram_line_fetch.sv | 122 ++++++++++++
 tb/tb_sdram_line_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_line_fetch.sv
// sdram_line_fetch: burst line reader for sdram_ctrl with FWFT word FIFO output.
//
// Optional feature macro: SDRAM_LINE_FETCH_STATS_EN (builds lines_o/stall_o counters).
//
// Ports:
//   sdram_clk, sdram_rst_n       clock, asynchronous active-low reset
//   req_valid_i/req_ready_o      line request handshake, req_adr_i byte address
//   out_valid_o/out_ready_i      word stream handshake, out_dat_o word, out_last_o end of line
//   sc_idle_i, sc_adr_o,
//   sc_acc_o, sc_we_o,
//   sc_ack_i, sc_dat_i           sdram_ctrl access interface
//   err_o                        sticky: ack seen while no burst was outstanding
//   lines_o, stall_o             completed-line and wait-cycle counters
module sdram_line_fetch #(
    parameter int BURST_LEN  = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_adr_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [15:0]           out_dat_o,
    output logic                  out_last_o,
    input  logic                  sc_idle_i,
    output logic [31:0]           sc_adr_o,
    output logic                  sc_acc_o,
    output logic                  sc_we_o,
    input  logic                  sc_ack_i,
    input  logic [15:0]           sc_dat_i,
    output logic                  err_o,
    output logic [15:0]           lines_o,
    output logic [15:0]           stall_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BURST_LEN) + 1;
    // a line is BURST_LEN 16-bit words, so the low log2(2*BURST_LEN) byte-address bits are dropped
    localparam logic [ADDR_WIDTH-1:0] ADR_MASK = ~ADDR_WIDTH'(2 * BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, WAIT_CTRL, BURST} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [BW-1:0]         beat;
    logic [16:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]         wp, rp;
    logic [AW:0]           count;
    logic                  empty, accept, push, pop, last_beat;

    assign empty       = count == '0;
    // space is only checked here; nothing else pushes, so an accepted line always fits
    assign req_ready_o = state == IDLE && count <= (AW+1)'(FIFO_DEPTH - BURST_LEN);
    assign accept      = req_valid_i && req_ready_o;
    assign last_beat   = beat == BW'(BURST_LEN - 1);
    assign push        = state == BURST && sc_ack_i;
    assign pop         = !empty && out_ready_i;
    assign out_valid_o = !empty;
    // gate the head with empty so the un-reset storage never leaks onto the outputs
    assign {out_last_o, out_dat_o} = empty ? 17'h0 : mem[rp];
    assign sc_adr_o    = 32'(adr_q);
    assign sc_acc_o    = state == BURST;
    assign sc_we_o     = 1'b0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = accept ? WAIT_CTRL : IDLE;
            WAIT_CTRL: state_nxt = sc_idle_i ? BURST : WAIT_CTRL;
            BURST:     state_nxt = (sc_ack_i && last_beat) ? IDLE : BURST;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) state <= IDLE;
        else              state <= state_nxt;
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            adr_q <= '0;
            beat  <= '0;
            err_o <= 1'b0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (accept) adr_q <= req_adr_i & ADR_MASK;
            if (push) beat <= last_beat ? '0 : beat + 1'b1;
            // stray acks are dropped, only flagged
            if (sc_ack_i && state != BURST) err_o <= 1'b1;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (push) mem[wp] <= {last_beat, sc_dat_i};
    end

`ifdef SDRAM_LINE_FETCH_STATS_EN
    // stall counts cycles blocked on the controller or on FIFO space
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            lines_o <= '0;
            stall_o <= '0;
        end else begin
            if (push && last_beat && lines_o != 16'hFFFF) lines_o <= lines_o + 1'b1;
            if (((state == WAIT_CTRL && !sc_idle_i) || (state == IDLE && req_valid_i && !req_ready_o))
                && stall_o != 16'hFFFF) stall_o <= stall_o + 1'b1;
        end
    end
`else
    assign lines_o = '0;
    assign stall_o = '0;
`endif

endmodule

// File: tb/tb_sdram_line_fetch.sv
// tb_sdram_line_fetch: directed self-checking bench for sdram_line_fetch.
module tb_sdram_line_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_adr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_dat;
    logic        out_last;
    logic        sc_idle = 1'b1;
    logic [31:0] sc_adr;
    logic        sc_acc;
    logic        sc_we;
    logic        sc_ack = 1'b0;
    logic [15:0] sc_dat = '0;
    logic        err;
    logic [15:0] lines;
    logic [15:0] stall;

    int checks = 0;
    int failures = 0;
    logic [16:0] exp_q [$];

    sdram_line_fetch dut (
        .sdram_clk   (clk),
        .sdram_rst_n (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_adr_i   (req_adr),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_dat_o   (out_dat),
        .out_last_o  (out_last),
        .sc_idle_i   (sc_idle),
        .sc_adr_o    (sc_adr),
        .sc_acc_o    (sc_acc),
        .sc_we_o     (sc_we),
        .sc_ack_i    (sc_ack),
        .sc_dat_i    (sc_dat),
        .err_o       (err),
        .lines_o     (lines),
        .stall_o     (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] adr);
        bit got = 1'b0;
        req_valid = 1'b1;
        req_adr   = adr;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        step();
        req_valid = 1'b0;
        check("req_accept", 32'(got), 32'd1);
    endtask

    task automatic serve(input logic [31:0] adr, input logic [15:0] base);
        for (int i = 0; i < 20 && !sc_acc; i++) step();
        check("acc_seen", 32'(sc_acc), 32'd1);
        check("sc_adr", sc_adr, adr);
        for (int i = 0; i < 8; i++) begin
            sc_ack = 1'b1;
            sc_dat = base + 16'(i);
            exp_q.push_back({i == 7, base + 16'(i)});
            step();
        end
        sc_ack = 1'b0;
        check("acc_drop", 32'(sc_acc), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // scoreboard: every word the consumer takes must match the next expected word
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("word", 32'({out_last, out_dat}), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s0;
        bit          acc_seen;
        // reset values
        repeat (2) step();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_dat", 32'(out_dat), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_adr", sc_adr, 32'd0);
        check("rst_acc", 32'(sc_acc), 32'd0);
        check("rst_we", 32'(sc_we), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_lines", 32'(lines), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        step();

        // single line, acc rises one edge after accept
        out_ready = 1'b1;
        req(32'h1000);
        check("acc_pre", 32'(sc_acc), 32'd0);
        step();
        check("acc_rise", 32'(sc_acc), 32'd1);
        serve(32'h1000, 16'h1000);
        check("ready_after_burst", 32'(req_ready), 32'd1);
        drain();
        check("err_line1", 32'(err), 32'd0);

        // unaligned request is aligned to a 16-byte line
        req(32'h100A);
        serve(32'h1000, 16'hA000);
        drain();

        // backpressure: two lines fill the FIFO, third waits for space
        out_ready = 1'b0;
        req(32'h2000);
        serve(32'h2000, 16'h2000);
        req(32'h2010);
        serve(32'h2010, 16'h2010);
        req_valid = 1'b1;
        req_adr   = 32'h2020;
        acc_seen  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            acc_seen |= sc_acc;
        end
        check("full_ready", 32'(req_ready), 32'd0);
        check("full_no_acc", 32'(acc_seen), 32'd0);
        check("full_head", 32'({out_last, out_dat}), 32'h0_2000);
        out_ready = 1'b1;
        repeat (8) step();
        out_ready = 1'b0;
        req(32'h2020);
        serve(32'h2020, 16'h2020);
        out_ready = 1'b1;
        drain();

        // controller busy for 5 cycles after accept
        sc_idle = 1'b0;
        req(32'h3000);
        s0 = stall;
        acc_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            acc_seen |= sc_acc;
        end
        check("busy_no_acc", 32'(acc_seen), 32'd0);
        sc_idle = 1'b1;
        step();
        check("busy_acc", 32'(sc_acc), 32'd1);
`ifdef SDRAM_LINE_FETCH_STATS_EN
        check("stall_delta", 32'(stall - s0), 32'd5);
`else
        check("stall_zero", 32'(stall | s0), 32'd0);
`endif
        serve(32'h3000, 16'h3000);
        drain();

        // reset in the middle of a burst
        out_ready = 1'b0;
        req(32'h4000);
        for (int i = 0; i < 20 && !sc_acc; i++) step();
        for (int i = 0; i < 3; i++) begin
            sc_ack = 1'b1;
            sc_dat = 16'h4000 + 16'(i);
            step();
        end
        sc_ack = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_acc", 32'(sc_acc), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        sc_idle = 1'b0;
        out_ready = 1'b1;
        req(32'h5000);
        acc_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            acc_seen |= sc_acc;
        end
        check("postrst_wait", 32'(acc_seen), 32'd0);
        sc_idle = 1'b1;
        serve(32'h5000, 16'h5000);
        drain();
        check("err_clean", 32'(err), 32'd0);

        // stray ack in IDLE
        sc_ack = 1'b1;
        sc_dat = 16'hDEAD;
        step();
        sc_ack = 1'b0;
        check("stray_err", 32'(err), 32'd1);
        check("stray_valid", 32'(out_valid), 32'd0);
        repeat (3) step();
        check("stray_err_sticky", 32'(err), 32'd1);
        check("stray_valid_hold", 32'(out_valid), 32'd0);
        check("stray_ready", 32'(req_ready), 32'd1);
`ifdef SDRAM_LINE_FETCH_STATS_EN
        check("lines", 32'(lines), 32'd1);
`else
        check("lines", 32'(lines), 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
